// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - age-ordered ALU reservation station with CDB wakeup and registered issue
// Define ALU_IQ_CHECKS_EN to compile in the SVA checks.
package alu_iq_pkg;
  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        ALUSrc;
    logic [3:0]  ALUCtrl;
    logic        valid;
  } aluInStruct;
endpackage

module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [TAG_W-1:0]             disp_tag,
  input  logic [3:0]                   disp_ctrl,
  input  logic                         disp_alusrc,
  input  logic [31:0]                  disp_imm,
  input  logic                         disp_rs1_rdy,
  input  logic                         disp_rs2_rdy,
  input  logic [31:0]                  disp_rs1_val,
  input  logic [31:0]                  disp_rs2_val,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [31:0]                  cdb_value,
  output aluInStruct                   aluIn,
  output logic [TAG_W-1:0]             issue_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [3:0]       ctrl;
    logic             alusrc;
    logic [31:0]      imm;
    logic             r1_rdy;
    logic [31:0]      r1_val;
    logic [TAG_W-1:0] r1_tag;
    logic             r2_rdy;
    logic [31:0]      r2_val;
    logic [TAG_W-1:0] r2_tag;
  } entry_t;

  entry_t           q    [DEPTH];
  entry_t           woke [DEPTH];
  entry_t           nq   [DEPTH];
  entry_t           new_e;
  logic [DEPTH-1:0] vld, nvld, rdy;
  logic [IW-1:0]    sel;
  logic             issue_en;
  logic             disp_fire;
  logic [CW-1:0]    widx;

  assign disp_ready = (count < CW'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign widx       = count - CW'(issue_en);

  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = vld[i] && q[i].r1_rdy && (q[i].alusrc || q[i].r2_rdy);
  end

  // Descending scan leaves the lowest (oldest) ready index in sel.
  always_comb begin
    sel      = '0;
    issue_en = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel      = IW'(i);
        issue_en = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (cdb_valid && vld[i] && !q[i].r1_rdy && q[i].r1_tag == cdb_tag) begin
        woke[i].r1_rdy = 1'b1;
        woke[i].r1_val = cdb_value;
      end
      if (cdb_valid && vld[i] && !q[i].r2_rdy && q[i].r2_tag == cdb_tag) begin
        woke[i].r2_rdy = 1'b1;
        woke[i].r2_val = cdb_value;
      end
    end
  end

  always_comb begin
    new_e        = '0;
    new_e.tag    = disp_tag;
    new_e.ctrl   = disp_ctrl;
    new_e.alusrc = disp_alusrc;
    new_e.imm    = disp_imm;
    new_e.r1_tag = disp_rs1_tag;
    new_e.r2_tag = disp_rs2_tag;
    new_e.r1_rdy = disp_rs1_rdy || (cdb_valid && disp_rs1_tag == cdb_tag);
    new_e.r1_val = disp_rs1_rdy ? disp_rs1_val : cdb_value;
    new_e.r2_rdy = disp_rs2_rdy || (cdb_valid && disp_rs2_tag == cdb_tag);
    new_e.r2_val = disp_rs2_rdy ? disp_rs2_val : cdb_value;
  end

  // Collapse over the issued slot, then drop the dispatched op at the new tail.
  always_comb begin
    logic [IW-1:0] src;
    src  = '0;
    nvld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nq[i]   = woke[i];
      nvld[i] = vld[i];
      if (issue_en && IW'(i) >= sel) begin
        src     = (i < DEPTH-1) ? IW'(i+1) : IW'(i);
        nq[i]   = woke[src];
        nvld[i] = (i < DEPTH-1) ? vld[src] : 1'b0;
      end
      if (disp_fire && CW'(i) == widx) begin
        nq[i]   = new_e;
        nvld[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      count     <= '0;
      aluIn     <= '0;
      issue_tag <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      vld         <= '0;
      count       <= '0;
      aluIn.valid <= 1'b0;
    end else begin
      vld   <= nvld;
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
      count <= count + CW'(disp_fire) - CW'(issue_en);
      if (issue_en) begin
        aluIn.rs1     <= q[sel].r1_val;
        aluIn.rs2     <= q[sel].r2_val;
        aluIn.imm     <= q[sel].imm;
        aluIn.ALUSrc  <= q[sel].alusrc;
        aluIn.ALUCtrl <= q[sel].ctrl;
        aluIn.valid   <= 1'b1;
        issue_tag     <= q[sel].tag;
      end else begin
        aluIn.valid <= 1'b0;
      end
    end
  end

`ifdef ALU_IQ_CHECKS_EN
  logic             last_cdb_v;
  logic [TAG_W-1:0] last_cdb_tag;
  logic [DEPTH-1:0] stale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cdb_v   <= 1'b0;
      last_cdb_tag <= '0;
    end else begin
      last_cdb_v   <= cdb_valid && !flush;
      last_cdb_tag <= cdb_tag;
    end
  end

  always_comb begin
    stale = '0;
    for (int i = 0; i < DEPTH; i++)
      stale[i] = vld[i] && ((!q[i].r1_rdy && q[i].r1_tag == last_cdb_tag) ||
                            (!q[i].r2_rdy && q[i].r2_tag == last_cdb_tag));
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
  a_issue_ready: assert property (@(posedge clk) disable iff (!rst_n) aluIn.valid |-> $past(rdy[sel]));
  a_no_full_disp: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(disp_valid && disp_ready && count == CW'(DEPTH)));
  a_contiguous: assert property (@(posedge clk) disable iff (!rst_n) ((vld + DEPTH'(1)) & vld) == '0);
  a_no_stale: assert property (@(posedge clk) disable iff (!rst_n) last_cdb_v |-> stale == '0);
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - self-checking bench for alu_issue_queue with a queue-level reference model
module tb_alu_issue_queue;
  import alu_iq_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic disp_valid = 1'b0, disp_alusrc = 1'b0, disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
  logic [TAG_W-1:0] disp_tag = '0, disp_rs1_tag = '0, disp_rs2_tag = '0, cdb_tag = '0;
  logic [3:0] disp_ctrl = '0;
  logic [31:0] disp_imm = '0, disp_rs1_val = '0, disp_rs2_val = '0, cdb_value = '0;
  logic cdb_valid = 1'b0;
  logic disp_ready;
  aluInStruct alu_in;
  logic [TAG_W-1:0] issue_tag;
  logic [2:0] count;

  int n_tests = 0, n_fail = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .disp_ctrl(disp_ctrl), .disp_alusrc(disp_alusrc), .disp_imm(disp_imm),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .aluIn(alu_in), .issue_tag(issue_tag), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    logic [3:0]  ctrl;
    logic        alusrc;
    logic [31:0] imm;
    logic        r1rdy;
    logic [31:0] r1val;
    logic [5:0]  r1tag;
    logic        r2rdy;
    logic [31:0] r2val;
    logic [5:0]  r2tag;
  } m_t;

  m_t mq[$];
  logic        e_valid = 1'b0, e_src = 1'b0, e_rs2_ok = 1'b1;
  logic [31:0] e_rs1 = '0, e_rs2 = '0, e_imm = '0;
  logic [3:0]  e_ctrl = '0;
  logic [5:0]  e_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: oldest ready op leaves, survivors hear the CDB, then the new op joins the tail.
  always @(posedge clk or negedge rst_n) begin
    int n0, pick;
    m_t ne;
    if (!rst_n) begin
      mq.delete();
      e_valid = 0; e_src = 0; e_rs2_ok = 1; e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_ctrl = 0; e_tag = 0;
    end else if (flush) begin
      mq.delete();
      e_valid = 0;
    end else begin
      n0 = mq.size();
      pick = -1;
      for (int i = 0; i < mq.size(); i++)
        if (pick < 0 && mq[i].r1rdy && (mq[i].alusrc || mq[i].r2rdy)) pick = i;
      if (pick >= 0) begin
        e_valid = 1; e_rs1 = mq[pick].r1val; e_rs2 = mq[pick].r2val; e_rs2_ok = mq[pick].r2rdy;
        e_imm = mq[pick].imm; e_src = mq[pick].alusrc; e_ctrl = mq[pick].ctrl; e_tag = mq[pick].tag;
        mq.delete(pick);
      end else begin
        e_valid = 0;
      end
      if (cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].r1rdy && mq[i].r1tag == cdb_tag) begin mq[i].r1rdy = 1; mq[i].r1val = cdb_value; end
          if (!mq[i].r2rdy && mq[i].r2tag == cdb_tag) begin mq[i].r2rdy = 1; mq[i].r2val = cdb_value; end
        end
      end
      if (disp_valid && n0 < DEPTH) begin
        ne.tag = disp_tag; ne.ctrl = disp_ctrl; ne.alusrc = disp_alusrc; ne.imm = disp_imm;
        ne.r1rdy = disp_rs1_rdy; ne.r1val = disp_rs1_val; ne.r1tag = disp_rs1_tag;
        ne.r2rdy = disp_rs2_rdy; ne.r2val = disp_rs2_val; ne.r2tag = disp_rs2_tag;
        if (!ne.r1rdy && cdb_valid && ne.r1tag == cdb_tag) begin ne.r1rdy = 1; ne.r1val = cdb_value; end
        if (!ne.r2rdy && cdb_valid && ne.r2tag == cdb_tag) begin ne.r2rdy = 1; ne.r2val = cdb_value; end
        mq.push_back(ne);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("valid", alu_in.valid, e_valid);
    check("rs1", alu_in.rs1, e_rs1);
    if (e_rs2_ok) check("rs2", alu_in.rs2, e_rs2);
    check("imm", alu_in.imm, e_imm);
    check("alusrc", alu_in.ALUSrc, e_src);
    check("ctrl", alu_in.ALUCtrl, e_ctrl);
    check("issue_tag", issue_tag, e_tag);
    check("count", count, mq.size());
    check("disp_ready", disp_ready, mq.size() < DEPTH);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic send(input logic [5:0] tag, input logic [3:0] ctrl, input logic src, input logic [31:0] imm,
                      input logic r1rdy, input logic [31:0] r1val, input logic [5:0] r1tag,
                      input logic r2rdy, input logic [31:0] r2val, input logic [5:0] r2tag);
    disp_valid = 1; disp_tag = tag; disp_ctrl = ctrl; disp_alusrc = src; disp_imm = imm;
    disp_rs1_rdy = r1rdy; disp_rs1_val = r1val; disp_rs1_tag = r1tag;
    disp_rs2_rdy = r2rdy; disp_rs2_val = r2val; disp_rs2_tag = r2tag;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin
    idle();
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_ready", disp_ready, 1);
    check("rst_valid", alu_in.valid, 0);
    rst_n = 1;
    tick();

    // add with both operands ready
    send(3, 4'b0010, 0, 0, 1, 5, 0, 1, 7, 0);
    tick(); idle();
    tick();
    check("t1_valid", alu_in.valid, 1);
    check("t1_rs1", alu_in.rs1, 5);
    check("t1_rs2", alu_in.rs2, 7);
    check("t1_ctrl", alu_in.ALUCtrl, 4'b0010);
    check("t1_tag", issue_tag, 3);
    tick();
    check("t1_done_valid", alu_in.valid, 0);
    check("t1_done_count", count, 0);

    // rs1 waits on tag 9
    send(4, 4'b0010, 0, 0, 0, 0, 9, 1, 1, 0);
    tick(); idle();
    tick();
    check("t2_wait", alu_in.valid, 0);
    cdb(9, 32'h10);
    tick(); idle();
    check("t2_early", alu_in.valid, 0);
    tick();
    check("t2_valid", alu_in.valid, 1);
    check("t2_rs1", alu_in.rs1, 32'h10);
    check("t2_tag", issue_tag, 4);
    tick();

    // dispatch-cycle bypass of rs2
    send(6, 4'b0011, 0, 0, 1, 2, 0, 0, 0, 12);
    cdb(12, 32'hAB);
    tick(); idle();
    tick();
    check("t3_valid", alu_in.valid, 1);
    check("t3_rs2", alu_in.rs2, 32'hAB);
    tick();

    // fill, ignored fifth dispatch, out-of-order wake
    for (int i = 0; i < 4; i++) begin
      send(6'(30 + i), 4'b0010, 0, 0, 0, 0, 6'(20 + i), 1, i, 0);
      tick();
    end
    check("t4_full_count", count, 4);
    check("t4_full_ready", disp_ready, 0);
    send(40, 4'b0010, 0, 0, 1, 1, 0, 1, 1, 0);
    tick(); idle();
    check("t4_ignored", count, 4);
    cdb(22, 32'h22);
    tick(); idle();
    tick();
    check("t4_tag", issue_tag, 32);
    check("t4_count", count, 3);
    check("t4_ready", disp_ready, 1);
    cdb(20, 1); tick();
    cdb(21, 2); tick();
    cdb(23, 3); tick();
    idle(); tick(); tick();
    check("t4_drained", count, 0);

    // issue order 1, 2, then addi 5
    send(1, 4'b0010, 0, 0, 1, 100, 0, 1, 200, 0);
    tick();
    send(2, 4'b0110, 0, 0, 1, 300, 0, 1, 50, 0);
    tick();
    check("t5_first", issue_tag, 1);
    send(5, 4'b0010, 1, 4, 1, 10, 0, 0, 0, 50);
    tick(); idle();
    check("t5_second", issue_tag, 2);
    tick();
    check("t5_third", issue_tag, 5);
    check("t5_src", alu_in.ALUSrc, 1);
    check("t5_imm", alu_in.imm, 4);
    tick();

    // flush with three waiting ops
    for (int i = 0; i < 3; i++) begin
      send(6'(60 + i), 4'b0000, 0, 0, 0, 0, 6'(25 + i), 1, 0, 0);
      tick();
    end
    check("t6_pre", count, 3);
    send(63, 4'b0001, 0, 0, 1, 1, 0, 1, 1, 0);
    cdb(25, 32'h55);
    flush = 1;
    tick(); idle();
    check("t6_count", count, 0);
    check("t6_valid", alu_in.valid, 0);
    tick();

    // async reset mid-cycle
    send(7, 4'b0011, 0, 0, 1, 32'hF0, 0, 1, 32'h0F, 0);
    tick();
    send(8, 4'b1110, 0, 0, 0, 0, 40, 1, 2, 0);
    tick(); idle();
    #2 rst_n = 0;
    #1;
    check("ar_count", count, 0);
    check("ar_ready", disp_ready, 1);
    check("ar_valid", alu_in.valid, 0);
    check("ar_rs1", alu_in.rs1, 0);
    check("ar_tag", issue_tag, 0);
    tick();
    rst_n = 1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Age-ordered reservation station that feeds the ALU. It sits between dispatch and the ALU, and it is the producing end of the `aluInStruct` interface. It holds up to DEPTH ALU micro-ops, captures missing source operands from the common data bus (CDB), and issues the oldest fully-ready entry each cycle as a registered `aluInStruct`. The ALU is combinational and always accepts, so issue has no back-pressure.

## Interface
- DEPTH, 4: number of entries (2..16).
- TAG_W, 6: physical-tag width.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of all entries and the issue register.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; equals count < DEPTH.
- disp_tag  in  TAG_W  destination tag of the micro-op.
- disp_ctrl  in  4  ALUCtrl (and 0000, or 0001, add 0010, xor 0011, sub 0110, sra 1110).
- disp_alusrc  in  1  1 = use disp_imm as operand B.
- disp_imm  in  32  immediate.
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  source value already available.
- disp_rs1_val, disp_rs2_val  in  32 each  source values, meaningful when ready.
- disp_rs1_tag, disp_rs2_tag  in  TAG_W each  producer tags, meaningful when not ready.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  32  broadcast value.
- aluIn  out  aluInStruct  registered issue: rs1, rs2, imm, ALUSrc, ALUCtrl, valid.
- issue_tag  out  TAG_W  destination tag of the issued op, aligned with aluIn.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a collapsing queue: entry 0 is the oldest, and valid entries are contiguous from 0.
- Each entry holds tag, ctrl, alusrc, imm, rs1 {rdy, val, tag} and rs2 {rdy, val, tag}.
- Dispatch handshake: a transfer occurs when disp_valid && disp_ready. The new entry is written at index count, or count−1 if an issue occurs in the same cycle.
- disp_valid with disp_ready=0 is ignored, and no state changes.
- Dispatch bypass: if cdb_valid and cdb_tag matches a not-ready disp source tag in the same cycle, the entry is written with that source ready and holding cdb_value.
- Wakeup: every valid entry with a not-ready source whose tag equals cdb_tag (cdb_valid=1) sets that source ready and captures cdb_value at the edge.
  - One broadcast may wake both sources of an entry and any number of entries.
- An entry is ready when rs1.rdy && (alusrc || rs2.rdy). When alusrc=1, rs2 readiness is ignored.
- Select picks the lowest-index ready entry, which is the oldest, from the registered state. A wakeup does not make an entry eligible in the same cycle.
- Issue: on the edge, the issue register loads rs1.val, rs2.val, imm, alusrc, ctrl, tag and sets valid=1. The selected entry is removed and younger entries shift down one.
  - With no ready entry, aluIn.valid=0 and the other fields hold their previous values.
- count is incremented on dispatch, decremented on issue, and unchanged when both occur in the same cycle.
- flush: on the edge, all entries are invalidated, count=0 and aluIn.valid=0. A dispatch in the flush cycle is dropped, and CDB activity in that cycle has no effect.

## Timing
- Reset (rst_n=0, async): all entries invalid, count=0, aluIn all fields 0 (valid=0), issue_tag=0, disp_ready=1.
- Reset mid-operation discards all content immediately.
- Latency: a ready op dispatched at edge N is selected in cycle N+1 and appears on aluIn in cycle N+2 (valid for exactly one cycle).
- Wakeup latency: CDB at edge N leads to aluIn valid in cycle N+2 at earliest.
- Throughput: one issue per cycle and one dispatch per cycle.
- disp_ready is combinational from count only; it does not anticipate a same-cycle issue.
- Full queue with a simultaneous issue: disp_ready=0, so the freed slot is usable from the next cycle.

## Configuration
- ALU_IQ_CHECKS_EN defined: SVA properties are compiled in:
  - count ≤ DEPTH.
  - aluIn.valid implies the issued entry was ready.
  - No accepted dispatch while count==DEPTH.
  - Valid entries are contiguous.
  - No entry holds a not-ready source whose tag equals a valid same-cycle cdb_tag after the edge.
  - All properties are disabled during reset.
- ALU_IQ_CHECKS_EN undefined: no assertions are present. Functional behaviour is identical.

## Test plan
- Dispatch add (ctrl 0010), rs1=5 and rs2=7 ready, tag 3, at edge 0 → cycle 2 shows aluIn.valid=1, rs1=5, rs2=7, ALUCtrl=0010, issue_tag=3; cycle 3 shows valid=0, count=0.
- Dispatch with rs1 waiting on tag 9 and rs2=1 ready; CDB {9, 0x10} two cycles later → issue 2 cycles after the broadcast with rs1=0x10; no issue before that.
- CDB {12, 0xAB} in the same cycle as dispatching an op whose rs2 waits on tag 12 → captured via bypass; issue 2 cycles later with rs2=0xAB.
- Dispatch 4 ops waiting on tags 20..23 → count=4, disp_ready=0, a fifth disp_valid is ignored. Broadcast 22 → tag of the third entry issues, count=3, disp_ready=1.
- Two ready ops tagged 1 then 2, plus one addi (alusrc=1, rs2 not ready, imm=4) tagged 5 → issue order 1, 2, 5 on consecutive cycles; addi shows ALUSrc=1, imm=4.
- Queue holding 3 ops: flush → next cycle count=0, aluIn.valid=0. Async rst_n low mid-cycle → outputs go to reset values before the next edge.
